// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// Receive controller for one UART channel: buffers received words in a small FIFO
// and exposes data/status/control registers on a Wishbone classic slave port.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_rx_data,
  input  logic                 i_rx_ready,
  input  logic                 i_rx_busy,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [1:0]           i_wb_addr,
  input  logic [7:0]           i_wb_data,
  output logic                 o_wb_ack,
  output logic [7:0]           o_wb_data,
  output logic                 o_irq
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_ACK} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 irq_en_q, irq_en_d;
  logic [3:0]           thr_q, thr_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 ack_d, irq_d;

  logic       req, empty, full, pop, push, ovr_set, w1c;
  logic [3:0] thr_eff;
  logic [7:0] status_byte;

  always_comb begin
    state_d   = S_IDLE;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    irq_en_d  = irq_en_q;
    thr_d     = thr_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;

    // A strobe lingering in S_ACK belongs to the transfer being acknowledged.
    req     = (state_q == S_IDLE) && i_wb_cyc && i_wb_stb;
    empty   = (count_q == '0);
    full    = (count_q == CW'(FIFO_DEPTH));
    pop     = req && !i_wb_we && (i_wb_addr == 2'd0) && !empty;
    push    = i_rx_ready && (!full || pop);
    ovr_set = i_rx_ready && full && !pop;
    w1c     = req && i_wb_we && (i_wb_addr == 2'd1) && i_wb_data[2];
    thr_eff = (thr_q == 4'd0) ? 4'd1 : thr_q;
    status_byte = {4'(count_q), i_rx_busy, overrun_q, full, !empty};

    overrun_d = ovr_set || (overrun_q && !w1c);

    if (req) begin
      state_d = S_ACK;
      ack_d   = 1'b1;
      if (i_wb_we) begin
        rdata_d = i_wb_data;
        if (i_wb_addr == 2'd2) begin
          irq_en_d = i_wb_data[0];
          thr_d    = i_wb_data[7:4];
        end
      end else begin
        unique case (i_wb_addr)
          2'd0:    rdata_d = empty ? 8'h00 : 8'(mem_q[rptr_q]);
          2'd1:    rdata_d = status_byte;
          2'd2:    rdata_d = {thr_q, 3'b000, irq_en_q};
          default: rdata_d = 8'h00;
        endcase
      end
    end

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    irq_d = irq_en_q && (overrun_q || (5'(count_q) >= 5'(thr_eff)));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
      thr_q     <= 4'd0;
      rdata_q   <= 8'h00;
      o_wb_ack  <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      irq_en_q  <= irq_en_d;
      thr_q     <= thr_d;
      rdata_q   <= rdata_d;
      o_wb_ack  <= ack_d;
      o_irq     <= irq_d;
    end
  end

  // Storage carries no reset so it maps onto plain distributed/block memory.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= i_rx_data;
  end

  assign o_wb_data = rdata_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
// Scoreboarded bench for uart_rx_ctrl: a queue-based reference model predicts each
// bus response and the irq level; a monitor compares on every acknowledge.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0, rx_busy = 1'b0;
  logic       wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [1:0] wb_addr = 2'd0;
  logic [7:0] wb_wdata = 8'h00;
  logic       wb_ack, irq;
  logic [7:0] wb_rdata;

  uart_rx_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_ready(rx_ready),
    .i_rx_busy(rx_busy), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .o_wb_ack(wb_ack),
    .o_wb_data(wb_rdata), .o_irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {bit chk; logic [7:0] val; logic [1:0] addr;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] m_q[$];
  bit         m_ovr = 0, m_en = 0, m_ack = 0;
  logic [3:0] m_thr = 4'd0;
  bit         rand_busy = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit m_irq();
    int t;
    t = (m_thr == 4'd0) ? 1 : int'(m_thr);
    return m_en && (m_ovr || (m_q.size() >= t));
  endfunction

  // One clock of stimulus entered and left at a falling edge.
  task automatic step(input bit rxv, input logic [7:0] rxd, input bit cyc, input bit stb,
                      input bit we, input logic [1:0] a, input logic [7:0] wd, input int exp_c);
    bit irq_pred, acc, pop, full;
    exp_t e;
    logic [7:0] mv;
    rx_busy  = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
    rx_ready = rxv; rx_data = rxd;
    wb_cyc = cyc; wb_stb = stb; wb_we = we; wb_addr = a; wb_wdata = wd;
    irq_pred = m_irq();
    acc  = cyc && stb && !m_ack;
    full = (m_q.size() == DEPTH);
    pop  = 0;
    if (acc) begin
      case (a)
        2'd0:    mv = (m_q.size() != 0) ? m_q[0] : 8'h00;
        2'd1:    mv = {4'(m_q.size()), rx_busy, m_ovr, full, m_q.size() != 0};
        2'd2:    mv = {m_thr, 3'b000, m_en};
        default: mv = 8'h00;
      endcase
      e.chk  = !we;
      e.val  = (exp_c >= 0) ? 8'(exp_c) : mv;
      e.addr = a;
      sb.push_back(e);
      if (!we && a == 2'd0 && m_q.size() != 0) begin
        pop = 1;
        void'(m_q.pop_front());
      end
      if (we && a == 2'd2) begin m_en = wd[0]; m_thr = wd[7:4]; end
      if (we && a == 2'd1 && wd[2]) m_ovr = 0;
    end
    if (rxv) begin
      if (full && !pop) m_ovr = 1;
      else m_q.push_back(rxd);
    end
    m_ack = acc;
    @(posedge clk); #1;
    chk("irq", {7'd0, irq}, {7'd0, irq_pred});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 2'd0, 8'h00, -1);
  endtask
  task automatic push(input logic [7:0] b);
    step(1, b, 0, 0, 0, 2'd0, 8'h00, -1);
  endtask
  task automatic rd(input logic [1:0] a, input int exp_c);
    step(0, 8'h00, 1, 1, 0, a, 8'h00, exp_c);
    idle(1);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(0, 8'h00, 1, 1, 1, a, d, -1);
    idle(1);
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_ack) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 expected no transfer at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) chk($sformatf("rdata_addr%0d", mon_e.addr), wb_rdata, mon_e.val);
      end
    end
  end

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ack_in_reset", {7'd0, wb_ack}, 8'h00);
      chk("irq_in_reset", {7'd0, irq}, 8'h00);
    end
    rst_n = 1'b1;
    idle(1);
    rd(2'd1, 8'h00);

    // Ordered drain
    push(8'h41); push(8'h42); push(8'h43);
    rd(2'd1, 8'h31);
    rd(2'd0, 8'h41); rd(2'd0, 8'h42); rd(2'd0, 8'h43);
    rd(2'd0, 8'h00);
    rd(2'd1, 8'h00);

    // Overrun
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
    rd(2'd1, 8'h87);
    for (int i = 0; i < 8; i++) rd(2'd0, 8'(8'h10 + i));
    wr(2'd1, 8'h04);
    rd(2'd1, 8'h00);

    // Simultaneous push/pop while full
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    step(1, 8'hAA, 1, 1, 0, 2'd0, 8'h00, 8'h20);
    idle(1);
    rd(2'd1, 8'h83);
    for (int i = 1; i < 8; i++) rd(2'd0, 8'(8'h20 + i));
    rd(2'd0, 8'hAA);
    rd(2'd1, 8'h00);

    // Interrupt
    wr(2'd2, 8'h31);
    rd(2'd2, 8'h31);
    push(8'h01); push(8'h02); idle(1);
    chk("irq_below_thr", {7'd0, irq}, 8'h00);
    push(8'h03);
    chk("irq_lag", {7'd0, irq}, 8'h00);
    idle(1);
    chk("irq_at_thr", {7'd0, irq}, 8'h01);
    rd(2'd0, 8'h01);
    chk("irq_after_pop", {7'd0, irq}, 8'h00);
    rd(2'd0, 8'h02); rd(2'd0, 8'h03);
    wr(2'd2, 8'hF1);
    for (int i = 0; i < 9; i++) push(8'(8'h50 + i));
    idle(1);
    chk("irq_overrun", {7'd0, irq}, 8'h01);
    wr(2'd1, 8'h04);
    chk("irq_cleared", {7'd0, irq}, 8'h00);
    for (int i = 0; i < 8; i++) rd(2'd0, 8'(8'h50 + i));
    wr(2'd2, 8'h00);

    // Randomized traffic, including held strobes and cyc-less strobes
    rand_busy = 1;
    for (int it = 0; it < 700; it++) begin
      int op;
      bit we, hold;
      logic [1:0] a;
      op   = $urandom_range(0, 9);
      a    = 2'($urandom_range(0, 3));
      we   = (a == 2'd0) ? 1'b0 : 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 3) == 0);
      if (op < 5) begin
        step(1'($urandom_range(0, 2) == 0), 8'($urandom), 1, 1, we, a, 8'($urandom), -1);
        step(1'($urandom_range(0, 2) == 0), 8'($urandom), hold, hold, we, a, 8'($urandom), -1);
      end else if (op == 5) begin
        step(1'($urandom_range(0, 1)), 8'($urandom), 0, 1, we, a, 8'($urandom), -1);
      end else begin
        step(1'($urandom_range(0, 1)), 8'($urandom), 0, 0, 0, 2'd0, 8'h00, -1);
      end
    end
    rand_busy = 0;
    idle(2);

    // Reset mid-operation
    wr(2'd2, 8'h21);
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    idle(1);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'd0;
    @(posedge clk); #1;
    chk("ack_before_rst", {7'd0, wb_ack}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("ack_async_drop", {7'd0, wb_ack}, 8'h00);
    chk("irq_async_drop", {7'd0, irq}, 8'h00);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    m_q.delete(); m_ovr = 0; m_en = 0; m_thr = 4'd0; m_ack = 0;
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    rd(2'd1, 8'h00);
    rd(2'd2, 8'h00);
    rd(2'd0, 8'h00);
    idle(3);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_ack: got %0d pending transfers expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Wishbone-facing receive controller for the UART receiver. It captures each byte the receiver flags with its one-cycle data-ready strobe into a small FIFO and tracks overrun. It exposes data, status and control registers to a Wishbone classic slave port and raises a level interrupt from a programmable fill threshold. It sits between the UART receiver and the bus interconnect, one instance per UART channel.

## Interface
- DATA_BITS, 8, receive word width; must be ≤ 8
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..8
- i_clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_rx_data  input  DATA_BITS  received word from UART receiver
- i_rx_ready  input  1  one-cycle strobe: i_rx_data valid this cycle
- i_rx_busy  input  1  receiver busy flag, reported in STATUS
- i_wb_cyc  input  1  Wishbone cycle
- i_wb_stb  input  1  Wishbone strobe
- i_wb_we  input  1  write enable
- i_wb_addr  input  2  register select
- i_wb_data  input  8  write data
- o_wb_ack  output  1  transfer acknowledge
- o_wb_data  output  8  read data, registered
- o_irq  output  1  level interrupt, registered

## Operation
- Register map:
  - addr 0 DATA (R): FIFO head, zero-extended; the read pops one entry. Writes are ignored.
  - addr 1 STATUS (R/W1C):
    - bit0 not_empty, bit1 full, bit2 overrun (sticky), bit3 rx_busy, bits[7:4] count.
    - Writing 1 to bit2 clears overrun; other bits are read-only.
  - addr 2 CTRL (R/W): bit0 irq_en, bits[7:4] threshold; other bits read 0.
  - addr 3: reads 0x00, writes ignored, still acked.
- Bus FSM, two states:
  - IDLE: on cyc&stb, perform the access and go to ACK.
  - ACK: o_wb_ack=1 for exactly one cycle, then return to IDLE. A strobe still high during ACK is not a new request.
- Access effects (pop, register write, W1C) occur on the IDLE→ACK edge. o_wb_data is loaded on the same edge and is valid while ack=1.
- FIFO: circular buffer with write/read pointers of log2(FIFO_DEPTH) bits that wrap modulo depth. The count is log2(FIFO_DEPTH)+1 bits.
- Push on i_rx_ready:
  - Not full: write and increment count.
  - Full: drop the byte, set overrun, leave pointers and count unchanged.
- Pop on DATA read:
  - Not empty: return head and advance the read pointer.
  - Empty: return 0x00; state unchanged.
- Simultaneous push and pop:
  - Not empty: both occur, count unchanged.
  - Empty: the pop returns 0x00 and the push lands.
  - Full: the pop frees a slot, so the push lands; no overrun.
- Overrun set and W1C clear in the same cycle: set wins.
- Threshold 0 is treated as 1.
- o_irq next = irq_en & (overrun | count ≥ threshold).
- Reset values:
  - Pointers, count, overrun, CTRL: 0.
  - o_wb_ack=0, o_wb_data=0x00, o_irq=0, FSM=IDLE.
  - FIFO contents undefined.

## Timing
- Read/write latency: ack in the cycle after the strobe is first sampled, so 2 cycles per transfer. At most one transfer every 2 cycles.
- A push at edge N is visible in STATUS to a read whose strobe is sampled at edge N+1 or later.
- o_irq reflects count/overrun/CTRL changes one cycle after the state update (1-cycle lag).
- A reset assertion mid-transfer drops ack immediately (async). No pop survives reset.
- No cyc qualification beyond the strobe: cyc low with stb high is ignored.

## Test plan
- **Reset.** Reset, then read STATUS → 0x00. o_irq=0, o_wb_ack low throughout reset.
- **Ordered drain.** Push 0x41, 0x42, 0x43, then read STATUS → 0x31. DATA reads → 0x41, 0x42, 0x43. A 4th DATA read → 0x00; then STATUS → 0x00.
- **Overrun.** Push 9 bytes 0x10..0x18 (depth 8), then read STATUS → 0x87 (count 8, overrun, full, not_empty). DATA reads return 0x10..0x17. Write STATUS 0x04, then STATUS → 0x00.
- **Simultaneous push/pop at full.** Fill with 8 bytes, then push 0xAA in the same cycle the DATA read is accepted. Overrun stays 0, count stays 8, and the last byte drained is 0xAA.
- **Interrupt.** Write CTRL 0x31, then push 2 bytes → o_irq=0. Push a 3rd byte → o_irq=1 one cycle after the count reaches 3. Read 1 byte → o_irq=0. Force an overrun → o_irq=1 until it is cleared.
- **Reset mid-operation.** With 5 bytes queued and a read in flight, assert i_rst_n low for 1 cycle. Then STATUS → 0x00 and CTRL → 0x00.
